uart_tx_axis: RTL and testbench
===============================

// Module: uart_tx_axis
// PURPOSE
//  AXI-Stream-to-UART transmitter; TX counterpart of the UART receiver, sharing its parameter set and frame format.
//  Accepts one Databits-wide word per handshake and serialises start, data (LSB first), optional parity and stop bits on txd.
//  Baud rate = Fclk / prescale. Sits between a byte source (FIFO, CPU regs) and the pad.
// PARAMETERS
//  Databits   8       data bits per frame, 5..9
//  Parity     "NONE"  "NONE" | "ODD" (~^data) | "EVEN" (^data) | "MARK" (1) | "SPACE" (0)
//  Stopbits   0       0: 1 stop bit, 1: 1.5 stop bits, 2: 2 stop bits; other values behave as 0
// PORTS
//  clk            in   1         clock
//  rst            in   1         reset, synchronous, active-high
//  s_axis_tdata   in   Databits  word to transmit
//  s_axis_tvalid  in   1         source has a word
//  s_axis_tready  out  1         block can accept a word (registered)
//  txd            out  1         UART serial output, idle high (registered)
//  busy           out  1         frame in progress (registered)
//  prescale       in   16        clocks per bit period
// BEHAVIOUR
//  - Reset values: txd=1, s_axis_tready=0 during rst, 1 in first cycle after rst deasserts; busy=0; state IDLE.
//  - FSM: IDLE -> START -> DATA -> [PARITY if Parity!="NONE"] -> STOP -> IDLE.
//  - IDLE: tready=1, txd=1, busy=0. Handshake (tvalid&tready) in cycle N:
//    latch tdata, latch P=prescale (P=0 treated as 1); in cycle N+1 tready=0, busy=1, txd=0 (START).
//  - Prescale sampled only at acceptance; changes mid-frame have no effect.
//  - START: txd=0 for P clks. DATA: bit i (i=0 first) for P clks each, bit counter 0..Databits-1.
//  - PARITY: computed from latched word; txd held P clks.
//  - STOP: txd=1 for P (Stopbits 0), P+(P>>1) (1), 2P (2) clks; 17-bit arithmetic, no wrap.
//  - Last STOP clk -> IDLE; tready=1 next cycle; txd stays 1 there.
//    Back-to-back words: 1 idle clk between stop end and next start bit.
//  - No handshake while not IDLE; tvalid held by source is not dropped, taken at next IDLE.
//  - tdata/tvalid ignored when tready=0; tvalid may rise/fall freely in IDLE (no latch without tready).
//  - Total frame = P*(1+Databits+parity_bit)+stop clks, +1 idle clk.
//  - Reset mid-frame: next cycle txd=1, busy=0, state IDLE, word discarded.
//  - Bit-period counter 16 bits (17 for 1.5/2 stop), loads length-1, decrements to 0.
// STRUCTURE
//  - Shared include uart_defs.vh: state encodings, parity mode checks, parity_bit derivation
//    ((Parity=="NONE")?0:1), stop-length function; used by RX and TX alike.
//  - Single module; no sub-module. Optional: uart_baud_cnt (load/decrement/zero flag) if RX is refactored to share it.
// TESTING
//  1. 8N1, prescale=4, send 0xA5 -> txd: 4 clk low, then 1,0,1,0,0,1,0,1 (4 clk each), 4 clk high; tready low 40 clks.
//  2. 8E1, prescale=8, 0x03 -> parity bit 0; 8O1 same word -> parity 1; loopback into UART_rx, error=0.
//  3. 8N2, prescale=6, and 8N1.5 -> stop high for 12 and 9 clks respectively before tready returns.
//  4. tvalid held high, 3 words 0x11,0x22,0x33 -> three frames, exactly 1 idle clk between; all match in RX loopback.
//  5. rst asserted mid data bit 3 -> next cycle txd=1, busy=0; after release new word 0x5A sent cleanly.
//  6. prescale changed 4->10 mid-frame -> current frame keeps 4; next frame uses 10; prescale=0 -> 1 clk/bit.

Source files
------------

// File: rtl/uart_tx_axis_pkg.sv
// uart_tx_axis_pkg
//   Shared UART definitions: FSM state encoding, parity modes, parity bit
//   derivation and stop-period length. Used by the UART TX (and RX) blocks.
package uart_tx_axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef enum logic [2:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN,
    PAR_MARK,
    PAR_SPACE
  } parity_mode_e;

  // Data is zero-extended to 9 bits by the caller; extra zeros do not
  // change the XOR reduction.
  function automatic logic parity_of(parity_mode_e mode, logic [8:0] data);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  // Stop period in clocks; 17 bits so 1.5 / 2 stop bits never wrap.
  function automatic logic [16:0] stop_len(logic [15:0] p, int unsigned stopbits);
    case (stopbits)
      1:       return {1'b0, p} + {2'b0, p[15:1]};
      2:       return {p, 1'b0};
      default: return {1'b0, p};
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_axis.sv
// uart_tx_axis
//   AXI-Stream to UART transmitter. Accepts one Databits-wide word per
//   handshake and shifts out start, data (LSB first), optional parity and
//   stop bits on txd at Fclk/prescale baud.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_axis_tdata    word to transmit
//   s_axis_tvalid   source has a word
//   s_axis_tready   block can accept a word (registered)
//   txd             serial output, idle high (registered)
//   busy            frame in progress (registered)
//   prescale        clocks per bit, sampled at acceptance (0 acts as 1)
module uart_tx_axis
  import uart_tx_axis_pkg::*;
#(
  parameter int unsigned Databits = 8,
  parameter string       Parity   = "NONE",
  parameter int unsigned Stopbits = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Databits-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic                txd,
  output logic                busy,
  input  logic [15:0]         prescale
);

  localparam int unsigned  IdxW    = $clog2(Databits);
  localparam parity_mode_e ParMode = (Parity == "ODD")   ? PAR_ODD   :
                                     (Parity == "EVEN")  ? PAR_EVEN  :
                                     (Parity == "MARK")  ? PAR_MARK  :
                                     (Parity == "SPACE") ? PAR_SPACE : PAR_NONE;
  localparam logic         HasParity = (ParMode != PAR_NONE);

  uart_state_e         state_q, state_d;
  logic                txd_q, txd_d;
  logic                tready_q, tready_d;
  logic                busy_q, busy_d;
  logic [Databits-1:0] data_q, data_d;
  logic [15:0]         p_q, p_d;
  logic [16:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [15:0]     p_in;
  logic [16:0]     bit_load;
  logic [16:0]     stop_load;
  logic [IdxW-1:0] idx_nxt;
  logic            par_bit;

  always_comb begin
    p_in      = (prescale == '0) ? 16'd1 : prescale;
    bit_load  = {1'b0, p_q} - 17'd1;
    stop_load = stop_len(p_q, Stopbits) - 17'd1;
    idx_nxt   = idx_q + IdxW'(1);
    par_bit   = parity_of(ParMode, 9'(data_q));

    state_d  = state_q;
    txd_d    = txd_q;
    tready_d = tready_q;
    busy_d   = busy_q;
    data_d   = data_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;

    case (state_q)
      ST_IDLE: begin
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b1;
        if (tready_q && s_axis_tvalid) begin
          data_d   = s_axis_tdata;
          p_d      = p_in;
          cnt_d    = {1'b0, p_in} - 17'd1;
          state_d  = ST_START;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
          tready_d = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          idx_d   = '0;
          txd_d   = data_q[0];
          cnt_d   = bit_load;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          if (idx_q == IdxW'(Databits - 1)) begin
            if (HasParity) begin
              state_d = ST_PARITY;
              txd_d   = par_bit;
              cnt_d   = bit_load;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
              cnt_d   = stop_load;
            end
          end else begin
            idx_d = idx_nxt;
            txd_d = data_q[idx_nxt];
            cnt_d = bit_load;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          cnt_d   = stop_load;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // tready rises in the idle clock that separates back-to-back frames.
          state_d  = ST_IDLE;
          txd_d    = 1'b1;
          busy_d   = 1'b0;
          tready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      txd_q    <= 1'b1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_axis.sv
// tb_uart_tx_axis
//   Directed bench for uart_tx_axis. Five instances cover 8N1, 8E1, 8O1,
//   8N2 and 8N1.5; txd is checked bit period by bit period against
//   hand-derived frames.
module tb_uart_tx_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  tvalid = '0;
  logic [4:0]  tready;
  logic [4:0]  txd;
  logic [4:0]  busy;
  logic [7:0]  tdata    [5];
  logic [15:0] prescale [5];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_axis #(.Databits(8), .Parity("NONE"), .Stopbits(0)) u_n1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
    .s_axis_tready(tready[0]), .txd(txd[0]), .busy(busy[0]), .prescale(prescale[0]));
  uart_tx_axis #(.Databits(8), .Parity("EVEN"), .Stopbits(0)) u_e1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
    .s_axis_tready(tready[1]), .txd(txd[1]), .busy(busy[1]), .prescale(prescale[1]));
  uart_tx_axis #(.Databits(8), .Parity("ODD"), .Stopbits(0)) u_o1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
    .s_axis_tready(tready[2]), .txd(txd[2]), .busy(busy[2]), .prescale(prescale[2]));
  uart_tx_axis #(.Databits(8), .Parity("NONE"), .Stopbits(2)) u_n2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
    .s_axis_tready(tready[3]), .txd(txd[3]), .busy(busy[3]), .prescale(prescale[3]));
  uart_tx_axis #(.Databits(8), .Parity("NONE"), .Stopbits(1)) u_n15 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[4]), .s_axis_tvalid(tvalid[4]),
    .s_axis_tready(tready[4]), .txd(txd[4]), .busy(busy[4]), .prescale(prescale[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period (or stop period): txd at lvl, busy high, tready low throughout.
  task automatic seg(input int d, input logic lvl, input int len, input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (txd[d] !== lvl || busy[d] !== 1'b1 || tready[d] !== 1'b0) errs++;
    end
    check(tag, errs, 0);
  endtask

  // Present a word and wait (bounded) for the handshake edge.
  task automatic send(input int d, input logic [7:0] w, input string tag);
    logic ok;
    @(negedge clk);
    tdata[d]  = w;
    tvalid[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tready[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".accept"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    tvalid[d] = 1'b0;
  endtask

  // Starts sampling in the first cycle after the handshake edge and ends on
  // the single idle cycle after the stop period.
  task automatic check_frame(input int d, input logic [7:0] w, input int p,
                             input logic par_en, input logic par_val,
                             input int stop, input string tag);
    seg(d, 1'b0, p, {tag, ".start"});
    for (int i = 0; i < 8; i++) seg(d, w[i], p, $sformatf("%s.d%0d", tag, i));
    if (par_en) seg(d, par_val, p, {tag, ".par"});
    seg(d, 1'b1, stop, {tag, ".stop"});
    @(negedge clk);
    check({tag, ".idle"}, {29'd0, txd[d], busy[d], tready[d]}, 32'b101);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      tdata[i]    = '0;
      prescale[i] = 16'd4;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("rst%0d", i), {29'd0, txd[i], busy[i], tready[i]}, 32'b100);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_tready", 32'(tready[0]), 32'd1);

    // 8N1, P=4, 0xA5
    send(0, 8'hA5, "n1_a5");
    check_frame(0, 8'hA5, 4, 1'b0, 1'b0, 4, "n1_a5");

    // 8E1 / 8O1, P=8, 0x03 -> parity 0 / 1
    prescale[1] = 16'd8;
    prescale[2] = 16'd8;
    send(1, 8'h03, "e1_03");
    check_frame(1, 8'h03, 8, 1'b1, 1'b0, 8, "e1_03");
    send(2, 8'h03, "o1_03");
    check_frame(2, 8'h03, 8, 1'b1, 1'b1, 8, "o1_03");

    // 8N2 and 8N1.5, P=6 -> stop 12 and 9
    prescale[3] = 16'd6;
    prescale[4] = 16'd6;
    send(3, 8'h5C, "n2_5c");
    check_frame(3, 8'h5C, 6, 1'b0, 1'b0, 12, "n2_5c");
    send(4, 8'hC3, "n15_c3");
    check_frame(4, 8'hC3, 6, 1'b0, 1'b0, 9, "n15_c3");

    // Back-to-back with tvalid held: exactly one idle clock between frames
    prescale[0] = 16'd3;
    @(negedge clk);
    tdata[0]  = 8'h11;
    tvalid[0] = 1'b1;
    @(posedge clk);
    #1;
    tdata[0] = 8'h22;
    check_frame(0, 8'h11, 3, 1'b0, 1'b0, 3, "b2b_11");
    @(posedge clk);
    #1;
    tdata[0] = 8'h33;
    check_frame(0, 8'h22, 3, 1'b0, 1'b0, 3, "b2b_22");
    @(posedge clk);
    #1;
    tvalid[0] = 1'b0;
    check_frame(0, 8'h33, 3, 1'b0, 1'b0, 3, "b2b_33");

    // Reset in the middle of data bit 3 (bit 3 of 0xF0 is 0)
    prescale[0] = 16'd4;
    send(0, 8'hF0, "rstmid");
    repeat (18) @(negedge clk);
    check("rstmid_bit3", {30'd0, txd[0], busy[0]}, 32'b01);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_out", {30'd0, txd[0], busy[0]}, 32'b10);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_idle", {29'd0, txd[0], busy[0], tready[0]}, 32'b101);
    send(0, 8'h5A, "after_rst");
    check_frame(0, 8'h5A, 4, 1'b0, 1'b0, 4, "after_rst");

    // Prescale change mid-frame is ignored until the next acceptance
    send(0, 8'h3C, "p4");
    prescale[0] = 16'd10;
    check_frame(0, 8'h3C, 4, 1'b0, 1'b0, 4, "p4");
    send(0, 8'h96, "p10");
    check_frame(0, 8'h96, 10, 1'b0, 1'b0, 10, "p10");
    prescale[0] = 16'd0;
    send(0, 8'h81, "p0");
    check_frame(0, 8'h81, 1, 1'b0, 1'b0, 1, "p0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
